// File: rtl/alsu.sv
// alsu: registered arithmetic/logic/shift unit on two 3-bit operands.
// Every input is registered first, then out/leds are computed from those
// registered copies, so a new input shows up at out two rising edges later.
// Illegal requests force out to zero and blink the LED bus at clk/2.
module alsu #(
    parameter string INPUT_PRIORITY = "A",   // "A" or "B": winner when both flags set
    parameter string FULL_ADDER     = "ON"   // "ON": A+B+cin, "OFF": A+B
) (
    input  logic        clk,
    input  logic        rst,                 // asynchronous, active low
    input  logic [2:0]  A,
    input  logic [2:0]  B,
    input  logic        cin,
    input  logic        serial_in,
    input  logic        red_op_A,
    input  logic        red_op_B,
    input  logic [2:0]  opcode,
    input  logic        bypass_A,
    input  logic        bypass_B,
    input  logic        direction,
    output logic [15:0] leds,
    output logic [5:0]  out
);

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_XOR   = 3'b001,
        OP_ADD   = 3'b010,
        OP_MUL   = 3'b011,
        OP_SHIFT = 3'b100,
        OP_ROT   = 3'b101,
        OP_RSV6  = 3'b110,
        OP_RSV7  = 3'b111
    } opcode_e;

    localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
    localparam bit USE_CIN = (FULL_ADDER == "ON");

    // Registered copies of every input.
    logic [2:0] a_r, b_r;
    logic       cin_r, serial_in_r, red_op_a_r, red_op_b_r;
    logic       bypass_a_r, bypass_b_r, direction_r;
    opcode_e    opcode_r;

    // Next-state values for the output registers.
    logic [5:0]  out_next;
    logic [15:0] leds_next;
    logic        invalid;
    logic [3:0]  sum;
    logic [5:0]  prod;
    logic [2:0]  sel_op;

    // Input capture stage: all requests sampled on each rising edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its sources, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r         <= '0;
            b_r         <= '0;
            cin_r       <= 1'b0;
            serial_in_r <= 1'b0;
            red_op_a_r  <= 1'b0;
            red_op_b_r  <= 1'b0;
            opcode_r    <= OP_AND;
            bypass_a_r  <= 1'b0;
            bypass_b_r  <= 1'b0;
            direction_r <= 1'b0;
        end else begin
            a_r         <= A;
            b_r         <= B;
            cin_r       <= cin;
            serial_in_r <= serial_in;
            red_op_a_r  <= red_op_A;
            red_op_b_r  <= red_op_B;
            opcode_r    <= opcode_e'(opcode);
            bypass_a_r  <= bypass_A;
            bypass_b_r  <= bypass_B;
            direction_r <= direction;
        end
    end

    // Result selection: invalid beats bypass, bypass beats the opcode.
    // NOTE: every variable gets a default at the top of the block, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        out_next  = out;
        leds_next = '0;
        sum       = 4'(a_r) + 4'(b_r) + 4'(cin_r & USE_CIN);
        prod      = 6'(a_r) * 6'(b_r);
        sel_op    = PRIO_A ? a_r : b_r;
        invalid   = (opcode_r == OP_RSV6) || (opcode_r == OP_RSV7) ||
                    ((red_op_a_r || red_op_b_r) &&
                     (opcode_r != OP_AND) && (opcode_r != OP_XOR));

        if (invalid) begin
            out_next  = '0;
            leds_next = ~leds;
        end else if (bypass_a_r || bypass_b_r) begin
            if (bypass_a_r && bypass_b_r) out_next = {3'b000, sel_op};
            else if (bypass_a_r)          out_next = {3'b000, a_r};
            else                          out_next = {3'b000, b_r};
        end else begin
            case (opcode_r)
                OP_AND: begin
                    if (red_op_a_r && red_op_b_r) out_next = {5'b0, &sel_op};
                    else if (red_op_a_r)          out_next = {5'b0, &a_r};
                    else if (red_op_b_r)          out_next = {5'b0, &b_r};
                    else                          out_next = {3'b000, a_r & b_r};
                end
                OP_XOR: begin
                    if (red_op_a_r && red_op_b_r) out_next = {5'b0, ^sel_op};
                    else if (red_op_a_r)          out_next = {5'b0, ^a_r};
                    else if (red_op_b_r)          out_next = {5'b0, ^b_r};
                    else                          out_next = {3'b000, a_r ^ b_r};
                end
                OP_ADD:   out_next = {2'b00, sum};
                OP_MUL:   out_next = prod;
                OP_SHIFT: out_next = direction_r ? {out[4:0], serial_in_r}
                                                 : {serial_in_r, out[5:1]};
                OP_ROT:   out_next = direction_r ? {out[4:0], out[5]}
                                                 : {out[0], out[5:1]};
                default:  out_next = '0;
            endcase
        end
    end

    // Output stage: result and LED registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out  <= '0;
            leds <= '0;
        end else begin
            out  <= out_next;
            leds <= leds_next;
        end
    end

endmodule

// File: tb/tb_alsu.sv
// tb_alsu: directed vectors with hand-computed expectations for alsu
// (default parameters: INPUT_PRIORITY "A", FULL_ADDER "ON").
module tb_alsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  A, B, opcode;
    logic        cin, serial_in, red_op_A, red_op_B;
    logic        bypass_A, bypass_B, direction;
    logic [15:0] leds;
    logic [5:0]  out;

    int vectors     = 0;
    int miscompares = 0;

    alsu dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .serial_in (serial_in),
        .red_op_A  (red_op_A),
        .red_op_B  (red_op_B),
        .opcode    (opcode),
        .bypass_A  (bypass_A),
        .bypass_B  (bypass_B),
        .direction (direction),
        .leds      (leds),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        A = 3'd0; B = 3'd0; opcode = 3'b000; cin = 1'b0; serial_in = 1'b0;
        red_op_A = 1'b0; red_op_B = 1'b0; bypass_A = 1'b0; bypass_B = 1'b0;
        direction = 1'b0;
    endtask

    // Load out = 000101 through bypass_A.
    task automatic load_five();
        clear_inputs();
        A = 3'd5; bypass_A = 1'b1;
        tick(); tick();
        check("load_five", {10'b0, out}, 16'h0005);
    endtask

    initial begin
        // ---------------- reset with random inputs ----------------
        rst = 1'b0;
        A = 3'($urandom); B = 3'($urandom); opcode = 3'($urandom);
        cin = 1'($urandom); serial_in = 1'($urandom);
        red_op_A = 1'($urandom); red_op_B = 1'($urandom);
        bypass_A = 1'($urandom); bypass_B = 1'($urandom); direction = 1'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out", {10'b0, out}, 16'h0000);
            check("rst_leds", leds, 16'h0000);
            A = 3'($urandom); opcode = 3'($urandom); red_op_A = 1'($urandom);
        end
        clear_inputs();
        A = 3'd5; B = 3'd3;
        rst = 1'b1;
        tick();
        check("post_rst_edge1", {10'b0, out}, 16'h0000);
        tick();
        check("post_rst_and", {10'b0, out}, 16'h0001);

        // ---------------- bypass ----------------
        clear_inputs(); A = 3'd6; B = 3'd2; bypass_A = 1'b1; bypass_B = 1'b1;
        tick(); tick();
        check("bypass_both", {10'b0, out}, 16'h0006);
        bypass_A = 1'b0;
        tick(); tick();
        check("bypass_b", {10'b0, out}, 16'h0002);
        bypass_A = 1'b1; bypass_B = 1'b0;
        tick(); tick();
        check("bypass_a", {10'b0, out}, 16'h0006);

        // ---------------- logic ----------------
        clear_inputs(); A = 3'd7; B = 3'd5; opcode = 3'b000;
        tick(); tick();
        check("and", {10'b0, out}, 16'h0005);
        red_op_A = 1'b1;
        tick(); tick();
        check("and_red_a", {10'b0, out}, 16'h0001);
        red_op_A = 1'b0; red_op_B = 1'b1; B = 3'd6;
        tick(); tick();
        check("and_red_b", {10'b0, out}, 16'h0000);
        red_op_A = 1'b1;   // both: A wins, &7 = 1
        tick(); tick();
        check("and_red_both", {10'b0, out}, 16'h0001);
        clear_inputs(); A = 3'd6; B = 3'd3; opcode = 3'b001;
        tick(); tick();
        check("xor", {10'b0, out}, 16'h0005);
        red_op_A = 1'b1;
        tick(); tick();
        check("xor_red_a", {10'b0, out}, 16'h0000);
        red_op_A = 1'b0; red_op_B = 1'b1; B = 3'd7;
        tick(); tick();
        check("xor_red_b", {10'b0, out}, 16'h0001);

        // ---------------- arithmetic ----------------
        clear_inputs(); A = 3'd7; B = 3'd7; cin = 1'b1; opcode = 3'b010;
        tick(); tick();
        check("add_max", {10'b0, out}, 16'h000F);
        A = 3'd3; B = 3'd2; cin = 1'b0;
        tick(); tick();
        check("add_nocin", {10'b0, out}, 16'h0005);
        clear_inputs(); A = 3'd7; B = 3'd7; opcode = 3'b011;
        tick(); tick();
        check("mul_max", {10'b0, out}, 16'd49);
        A = 3'd0; B = 3'd5;
        tick(); tick();
        check("mul_zero", {10'b0, out}, 16'h0000);

        // ---------------- shift / rotate from 000101 ----------------
        load_five();
        clear_inputs(); opcode = 3'b100; direction = 1'b1; serial_in = 1'b1;
        tick(); tick();
        check("shl", {10'b0, out}, 16'b001011);
        tick();
        check("shl_repeat", {10'b0, out}, 16'b010111);
        load_five();
        clear_inputs(); opcode = 3'b100; direction = 1'b0; serial_in = 1'b1;
        tick(); tick();
        check("shr", {10'b0, out}, 16'b100010);
        load_five();
        clear_inputs(); opcode = 3'b101; direction = 1'b0;
        tick(); tick();
        check("rotr", {10'b0, out}, 16'b100010);
        load_five();
        clear_inputs(); opcode = 3'b101; direction = 1'b1;
        tick(); tick();
        check("rotl", {10'b0, out}, 16'b001010);

        // ---------------- invalid: opcode 110 ----------------
        clear_inputs(); opcode = 3'b110;
        tick(); tick();
        check("inv110_out", {10'b0, out}, 16'h0000);
        check("inv110_leds1", leds, 16'hFFFF);
        tick();
        check("inv110_leds2", leds, 16'h0000);
        tick();
        check("inv110_leds3", leds, 16'hFFFF);
        clear_inputs(); A = 3'd7; B = 3'd3; opcode = 3'b000;
        tick(); tick();
        check("recover_leds", leds, 16'h0000);
        check("recover_out", {10'b0, out}, 16'h0003);

        // ---------------- invalid: reduction with add ----------------
        clear_inputs(); A = 3'd3; B = 3'd2; opcode = 3'b010; red_op_A = 1'b1;
        tick(); tick();
        check("invred_out", {10'b0, out}, 16'h0000);
        check("invred_leds1", leds, 16'hFFFF);
        tick();
        check("invred_leds2", leds, 16'h0000);
        tick();
        check("invred_leds3", leds, 16'hFFFF);

        // ---------------- reset mid-operation ----------------
        rst = 1'b0;
        #1;
        check("midrst_leds", leds, 16'h0000);
        check("midrst_out", {10'b0, out}, 16'h0000);
        tick();
        check("midrst_hold", leds, 16'h0000);
        clear_inputs(); A = 3'd3; B = 3'd2; opcode = 3'b010;
        rst = 1'b1;
        tick();
        check("midrst_edge1", {10'b0, out}, 16'h0000);
        tick();
        check("midrst_edge2", {10'b0, out}, 16'h0005);
        check("midrst_leds_after", leds, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alsu.md
Name: alsu

Overview:
- Registered arithmetic, logic, shift and rotate unit on two 3-bit operands, producing a 6-bit registered result.
- Covers bitwise/reduction AND and XOR, add, multiply, and serial shift/rotate of the output register.
- Illegal operation requests are flagged by blinking a 16-bit LED bus.
- Sits between board switches/buttons and display/LED logic.

Parameters:
- INPUT_PRIORITY, "A", operand chosen when both bypass flags or both reduction flags are set ("A" or "B").
- FULL_ADDER, "ON", "ON": add result is A+B+cin; "OFF": A+B (cin ignored).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- A  input  3  operand A.
- B  input  3  operand B.
- cin  input  1  carry-in for add.
- serial_in  input  1  fill bit for shift.
- red_op_A  input  1  reduction of A requested.
- red_op_B  input  1  reduction of B requested.
- opcode  input  3  operation select.
- bypass_A  input  1  pass A straight to out.
- bypass_B  input  1  pass B straight to out.
- direction  input  1  shift/rotate direction: 1 left, 0 right.
- leds  output  16  invalid-operation indicator.
- out  output  6  registered result.

Behaviour:
- Reset (rst=0, asynchronous):
  - All input registers, out and leds clear to 0.
  - Held while rst low.
- Pipeline:
  - Every input except clk/rst is captured into a register on each rising edge.
  - out and leds are computed from the registered copies and updated on the next edge.
  - Latency from input change to out is 2 rising edges.
- Priority, highest first: invalid > bypass > opcode.
- Invalid when:
  - registered opcode is 110 or 111; or
  - red_op_A or red_op_B is set with opcode other than 000/001.
- Invalid response:
  - out <= 0.
  - leds <= ~leds every clock, so the LEDs blink at clk/2 starting from 0 -> FFFF.
  - Any valid cycle: leds <= 0.
- Bypass:
  - bypass_A only: out <= {3'b0, A}.
  - bypass_B only: out <= {3'b0, B}.
  - Both set: operand chosen by INPUT_PRIORITY.
- opcode 000, AND:
  - red_op_A: out <= {5'b0, &A}.
  - red_op_B: out <= {5'b0, &B}.
  - Both set: operand chosen by INPUT_PRIORITY.
  - Neither set: out <= {3'b0, A&B}.
- opcode 001, XOR:
  - Same structure as AND using ^A, ^B and A^B.
- opcode 010, add:
  - FULL_ADDER "ON": out <= A+B+cin.
  - FULL_ADDER "OFF": out <= A+B.
  - Result is 4 bits, zero-extended; maximum is 15.
- opcode 011, multiply:
  - out <= A*B, 6-bit unsigned; maximum is 49.
- opcode 100, shift (operates on current out):
  - direction=1 (left): out <= {out[4:0], serial_in}.
  - direction=0 (right): out <= {serial_in, out[5:1]}.
- opcode 101, rotate (operates on current out):
  - direction=1 (left): out <= {out[4:0], out[5]}.
  - direction=0 (right): out <= {out[0], out[5:1]}.
- Shift and rotate repeat every cycle while the opcode is held.
- Reset asserted mid-operation clears everything immediately; the first valid result appears 2 edges after release.
- All arithmetic is unsigned; no overflow flag.

Test Plan:
- Reset: rst=0 with random inputs -> out=0, leds=0 at every edge. Release, then A=5, B=3, opcode=000 -> out=000001 after 2 edges.
- Bypass:
  - bypass_A=bypass_B=1, A=6, B=2, any valid opcode -> out=6 (INPUT_PRIORITY "A").
  - bypass_B only -> out=2.
- Logic:
  - opcode 000, A=7, B=5 -> out=5.
  - Same with red_op_A=1 -> out=1.
  - red_op_B=1, B=6 -> out=0.
  - opcode 001, A=6, B=3 -> out=5.
  - Same with red_op_A=1 -> out=0.
- Arithmetic:
  - opcode 010, A=7, B=7, cin=1 -> out=15.
  - opcode 011, A=7, B=7 -> out=49.
  - opcode 011, A=0, B=5 -> out=0.
- Shift/rotate, starting from out=000101:
  - Shift left with serial_in=1 -> 001011.
  - Shift right with serial_in=1 -> 100010.
  - Rotate right -> 100010.
  - Rotate left -> 001010.
- Invalid:
  - opcode 110 -> out=0, leds alternate FFFF/0000 each edge.
  - opcode 010 with red_op_A=1 -> same.
  - Returning to a valid opcode -> leds=0 within 2 edges.
